// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;

    // Controller state: grant in IDLE, hold memory flags in ACCESS, ack in DONE.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arbState_t;

    // Port indices as seen on the grant signal.
    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LSU   = 1'b1;

    // Latency counter width; MEM_LATENCY is limited to 1..15.
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter2: combinational round-robin pick between two requesters.
// Ports:
//   req0, req1  - request levels
//   lastGrant   - port served most recently (loses a tie)
//   grant       - chosen port index (PORT_FETCH / PORT_LSU)
//   grantValid  - at least one request is present
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic lastGrant,
    output logic grant,
    output logic grantValid
);

    // A tie goes to the port that was not served last; otherwise the sole requester wins.
    always_comb begin
        grantValid = req0 | req1;
        grant      = PORT_FETCH;
        if (req0 && req1) begin
            grant = ~lastGrant;
        end else if (req1) begin
            grant = PORT_LSU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported data Memory between instruction fetch
// (port 0, read-only) and load/store (port 1, read/write).
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   req0/addr0 -> ack0/rdata0     - fetch port, level request held until ack
//   req1/we1/addr1/wdata1 -> ack1/rdata1 - load/store port
//   memReadFlag/memWriteFlag/MemAddress/WriteDataInput -> Memory
//   ReadDataOutput                - read data from Memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              memReadFlag,
    output logic              memWriteFlag,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] WriteDataInput,
    input  logic [DATA_W-1:0] ReadDataOutput
);

    arbState_t        state;
    logic [CNT_W-1:0] cnt;
    logic             lastGrant;
    logic             grantPort;
    logic             latchedWe;
    logic             grant;
    logic             grantValid;

    rr_arbiter2 uRr (
        .req0       (req0),
        .req1       (req1),
        .lastGrant  (lastGrant),
        .grant      (grant),
        .grantValid (grantValid)
    );

    // Controller FSM with the latency counter and all memory-side/requester-side registers.
    // WriteDataInput is only reloaded on a write grant, so it simply holds across reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ARB_IDLE;
            cnt            <= '0;
            lastGrant      <= PORT_LSU;
            grantPort      <= PORT_FETCH;
            latchedWe      <= 1'b0;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            rdata0         <= '0;
            rdata1         <= '0;
            memReadFlag    <= 1'b0;
            memWriteFlag   <= 1'b0;
            MemAddress     <= '0;
            WriteDataInput <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grantValid) begin
                        grantPort <= grant;
                        cnt       <= CNT_W'(MEM_LATENCY);
                        state     <= ARB_ACCESS;
                        if (grant == PORT_LSU) begin
                            MemAddress   <= addr1;
                            latchedWe    <= we1;
                            memWriteFlag <= we1;
                            memReadFlag  <= ~we1;
                            if (we1) begin
                                WriteDataInput <= wdata1;
                            end
                        end else begin
                            // Fetch port is read-only.
                            MemAddress   <= addr0;
                            latchedWe    <= 1'b0;
                            memWriteFlag <= 1'b0;
                            memReadFlag  <= 1'b1;
                        end
                    end
                end
                ARB_ACCESS: begin
                    cnt <= cnt - CNT_W'(1);
                    // Last cycle of the window: capture read data and raise the ack.
                    if (cnt == CNT_W'(1)) begin
                        memReadFlag  <= 1'b0;
                        memWriteFlag <= 1'b0;
                        state        <= ARB_DONE;
                        if (grantPort == PORT_LSU) begin
                            ack1 <= 1'b1;
                            if (!latchedWe) begin
                                rdata1 <= ReadDataOutput;
                            end
                        end else begin
                            ack0   <= 1'b1;
                            rdata0 <= ReadDataOutput;
                        end
                    end
                end
                ARB_DONE: begin
                    memReadFlag  <= 1'b0;
                    memWriteFlag <= 1'b0;
                    lastGrant    <= grantPort;
                    state        <= ARB_IDLE;
                end
                default: begin
                    memReadFlag  <= 1'b0;
                    memWriteFlag <= 1'b0;
                    state        <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cycle vectors at MEM_LATENCY=1, a reset
// mid-access sequence at MEM_LATENCY=3, persistent-request alternation and a
// random protocol-following traffic run.
module tb_mem_arbiter;

    localparam logic        H  = 1'b1;
    localparam logic        L  = 1'b0;
    localparam logic [31:0] Z  = 32'h0;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    logic clk;
    logic memClear;

    // Instance A (MEM_LATENCY = 1)
    logic        resetA, req0A, ack0A, req1A, we1A, ack1A, rfA, wfA;
    logic [31:0] addr0A, rdata0A, addr1A, wdata1A, rdata1A, maA, wdiA, rdoA;
    // Instance B (MEM_LATENCY = 3)
    logic        resetB, req0B, ack0B, req1B, we1B, ack1B, rfB, wfB;
    logic [31:0] addr0B, rdata0B, addr1B, wdata1B, rdata1B, maB, wdiB, rdoB;

    logic [31:0] memA [0:63];
    logic [31:0] memB [0:63];

    int nCmp = 0;
    int nBad = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dutA (
        .clk(clk), .reset(resetA),
        .req0(req0A), .addr0(addr0A), .ack0(ack0A), .rdata0(rdata0A),
        .req1(req1A), .we1(we1A), .addr1(addr1A), .wdata1(wdata1A),
        .ack1(ack1A), .rdata1(rdata1A),
        .memReadFlag(rfA), .memWriteFlag(wfA), .MemAddress(maA),
        .WriteDataInput(wdiA), .ReadDataOutput(rdoA)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dutB (
        .clk(clk), .reset(resetB),
        .req0(req0B), .addr0(addr0B), .ack0(ack0B), .rdata0(rdata0B),
        .req1(req1B), .we1(we1B), .addr1(addr1B), .wdata1(wdata1B),
        .ack1(ack1B), .rdata1(rdata1B),
        .memReadFlag(rfB), .memWriteFlag(wfB), .MemAddress(maB),
        .WriteDataInput(wdiB), .ReadDataOutput(rdoB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: combinational read, write on the clock edge while memWriteFlag is high.
    assign rdoA = memA[maA[7:2]];
    assign rdoB = memB[maB[7:2]];

    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < 64; i++) begin
                memA[i] <= 32'hA000_0000 + 32'(i * 4);
                memB[i] <= 32'hA000_0000 + 32'(i * 4);
            end
        end else begin
            if (wfA) memA[maA[7:2]] <= wdiA;
            if (wfB) memB[maB[7:2]] <= wdiB;
        end
    end

    typedef struct {
        logic        rst, r0;
        logic [31:0] a0;
        logic        r1, we;
        logic [31:0] a1, wd;
        logic        k0, k1, rf, wf;
        logic [31:0] ma, wdi, rd0, rd1;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic r0, input logic [31:0] a0,
                                input logic r1, input logic we, input logic [31:0] a1,
                                input logic [31:0] wd, input logic k0, input logic k1,
                                input logic rf, input logic wf, input logic [31:0] ma,
                                input logic [31:0] wdi, input logic [31:0] rd0,
                                input logic [31:0] rd1);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.we = we; v.a1 = a1; v.wd = wd;
        v.k0 = k0; v.k1 = k1; v.rf = rf; v.wf = wf; v.ma = ma; v.wdi = wdi;
        v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [135:0] got, input logic [135:0] want);
        nCmp++;
        if (got !== want) begin
            nBad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [22];

    int          nAck;
    logic        pend0, pend1, curWe1, justAck0, justAck1;
    logic [31:0] curA0, curA1;
    int          iss0, iss1, acked0, acked1;

    initial begin
        // Inputs: rst r0 a0 r1 we a1 wd | ack0 ack1 rf wf MemAddress WriteDataInput rdata0 rdata1
        vecs[0]  = mk(H, L, Z,     L, L, Z,     Z,  L, L, L, L, Z,     Z,  Z,            Z);
        vecs[1]  = mk(H, L, Z,     L, L, Z,     Z,  L, L, L, L, Z,     Z,  Z,            Z);
        vecs[2]  = mk(H, L, Z,     L, L, Z,     Z,  L, L, L, L, Z,     Z,  Z,            Z);
        vecs[3]  = mk(L, H, 32'h4, L, L, Z,     Z,  L, L, H, L, 32'h4, Z,  Z,            Z);
        vecs[4]  = mk(L, H, 32'h4, L, L, Z,     Z,  H, L, L, L, 32'h4, Z,  32'hA000_0004, Z);
        vecs[5]  = mk(L, L, Z,     L, L, Z,     Z,  L, L, L, L, 32'h4, Z,  32'hA000_0004, Z);
        vecs[6]  = mk(L, L, Z, H, H, 32'h10, DB,    L, L, L, H, 32'h10, DB, 32'hA000_0004, Z);
        vecs[7]  = mk(L, L, Z, H, H, 32'h10, DB,    L, H, L, L, 32'h10, DB, 32'hA000_0004, Z);
        vecs[8]  = mk(L, L, Z, L, L, Z,      Z,     L, L, L, L, 32'h10, DB, 32'hA000_0004, Z);
        vecs[9]  = mk(L, L, Z, H, L, 32'h10, Z,     L, L, H, L, 32'h10, DB, 32'hA000_0004, Z);
        vecs[10] = mk(L, L, Z, H, L, 32'h10, Z,     L, H, L, L, 32'h10, DB, 32'hA000_0004, DB);
        vecs[11] = mk(L, L, Z, L, L, Z,      Z,     L, L, L, L, 32'h10, DB, 32'hA000_0004, DB);
        vecs[12] = mk(H, L, Z, L, L, Z,      Z,     L, L, L, L, Z,      Z,  Z,             Z);
        vecs[13] = mk(L, H, 32'h8, H, L, 32'h20, Z, L, L, H, L, 32'h8,  Z,  Z,             Z);
        vecs[14] = mk(L, H, 32'h8, H, L, 32'h20, Z, H, L, L, L, 32'h8,  Z,  32'hA000_0008, Z);
        vecs[15] = mk(L, L, Z,     H, L, 32'h20, Z, L, L, L, L, 32'h8,  Z,  32'hA000_0008, Z);
        vecs[16] = mk(L, H, 32'hC, H, L, 32'h20, Z, L, L, H, L, 32'h20, Z,  32'hA000_0008, Z);
        vecs[17] = mk(L, H, 32'hC, H, L, 32'h20, Z, L, H, L, L, 32'h20, Z,  32'hA000_0008, 32'hA000_0020);
        vecs[18] = mk(L, H, 32'hC, L, L, Z,      Z, L, L, L, L, 32'h20, Z,  32'hA000_0008, 32'hA000_0020);
        vecs[19] = mk(L, H, 32'hC, L, L, Z,      Z, L, L, H, L, 32'hC,  Z,  32'hA000_0008, 32'hA000_0020);
        vecs[20] = mk(L, H, 32'hC, L, L, Z,      Z, H, L, L, L, 32'hC,  Z,  32'hA000_000C, 32'hA000_0020);
        vecs[21] = mk(L, L, Z,     L, L, Z,      Z, L, L, L, L, 32'hC,  Z,  32'hA000_000C, 32'hA000_0020);

        memClear = 1'b1;
        resetB = 1'b1; req0B = 1'b0; addr0B = Z; req1B = 1'b0; we1B = 1'b0; addr1B = Z; wdata1B = Z;

        // Cycle-by-cycle vectors on instance A.
        for (int i = 0; i < 22; i++) begin
            resetA = vecs[i].rst; req0A = vecs[i].r0; addr0A = vecs[i].a0;
            req1A = vecs[i].r1; we1A = vecs[i].we; addr1A = vecs[i].a1; wdata1A = vecs[i].wd;
            tick();
            memClear = 1'b0;
            chk($sformatf("vec%0d", i),
                136'({ack0A, ack1A, rfA, wfA, maA, wdiA, rdata0A, rdata1A}),
                136'({vecs[i].k0, vecs[i].k1, vecs[i].rf, vecs[i].wf,
                      vecs[i].ma, vecs[i].wdi, vecs[i].rd0, vecs[i].rd1}));
        end

        // Reset in the second ACCESS cycle of a latency-3 read, then reissue.
        resetB = 1'b0; req0B = 1'b1; addr0B = 32'h4;
        tick();
        chk("rstmid_acc1", 136'({ack0B, ack1B, rfB, wfB}), 136'(4'b0010));
        tick();
        chk("rstmid_acc2", 136'({ack0B, ack1B, rfB, wfB}), 136'(4'b0010));
        resetB = 1'b1;
        tick();
        chk("rstmid_abort", 136'({ack0B, ack1B, rfB, wfB, rdata0B}), 136'({4'b0000, Z}));
        resetB = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("reissue_acc%0d", c), 136'({ack0B, ack1B, rfB, wfB}), 136'(4'b0010));
        end
        tick();
        req0B = 1'b0;
        chk("reissue_ack", 136'({ack0B, ack1B, rfB, wfB, rdata0B}), 136'({4'b1000, 32'hA000_0004}));
        tick();
        chk("reissue_done", 136'({ack0B, ack1B, rfB, wfB}), 136'(4'b0000));

        // Persistent requests on both ports: acks must alternate; lastGrant is 0 here.
        req0A = 1'b1; addr0A = 32'h4; req1A = 1'b1; we1A = 1'b0; addr1A = 32'h8;
        nAck = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (ack0A && ack1A) begin
                chk("persist_dual_ack", 136'({ack0A, ack1A}), 136'(2'b00));
            end else if (ack0A || ack1A) begin
                chk($sformatf("persist_order%0d", nAck), 136'(ack1A),
                    136'((nAck % 2 == 0) ? 1'b1 : 1'b0));
                nAck++;
            end
        end
        req0A = 1'b0; req1A = 1'b0;
        chk("persist_count", 136'(nAck), 136'(10));

        // Random protocol-following traffic with a drain phase.
        pend0 = 1'b0; pend1 = 1'b0; curWe1 = 1'b0; curA0 = Z; curA1 = Z;
        iss0 = 0; iss1 = 0; acked0 = 0; acked1 = 0;
        for (int c = 0; c < 230; c++) begin
            tick();
            chk($sformatf("excl%0d", c), 136'(rfA & wfA), 136'(1'b0));
            if (wfA) chk($sformatf("wr_owner%0d", c), 136'({pend1, curWe1}), 136'(2'b11));
            justAck0 = 1'b0;
            justAck1 = 1'b0;
            if (ack0A) begin
                if (!pend0) chk("spurious_ack0", 136'(ack0A), 136'(1'b0));
                else chk($sformatf("rd0_%0d", c), 136'(rdata0A), 136'(memA[curA0[7:2]]));
                pend0 = 1'b0; req0A = 1'b0; acked0++; justAck0 = 1'b1;
            end
            if (ack1A) begin
                if (!pend1) chk("spurious_ack1", 136'(ack1A), 136'(1'b0));
                else if (!curWe1) chk($sformatf("rd1_%0d", c), 136'(rdata1A), 136'(memA[curA1[7:2]]));
                pend1 = 1'b0; req1A = 1'b0; acked1++; justAck1 = 1'b1;
            end
            if (c < 200) begin
                if (!pend0 && !justAck0 && $urandom_range(0, 2) == 0) begin
                    curA0 = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                    addr0A = curA0; req0A = 1'b1; pend0 = 1'b1; iss0++;
                end
                if (!pend1 && !justAck1 && $urandom_range(0, 2) == 0) begin
                    curA1 = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                    curWe1 = 1'($urandom_range(0, 1));
                    addr1A = curA1; we1A = curWe1; wdata1A = $urandom(); req1A = 1'b1;
                    pend1 = 1'b1; iss1++;
                end
            end
        end
        chk("rand_acks0", 136'(acked0), 136'(iss0));
        chk("rand_acks1", 136'(acked1), 136'(iss1));
        chk("rand_idle", 136'({pend0, pend1}), 136'(2'b00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
